// File: rtl/quant_zigzag.sv
// quant_zigzag: quantizes one 8x8 block of signed DCT coefficients by
// per-coefficient reciprocals and streams the results in JPEG zigzag order.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   in_valid / in_ready     block handshake; in_ready only while idle
//   coef_in  [511:0]        64 signed 8-bit coefficients, natural index k at [8k+7:8k]
//   recip_in [1023:0]       64 unsigned 16-bit reciprocals round(65536/Q), index k at [16k+15:16k]
//   out_valid / out_ready   output beat handshake
//   out_data [7:0]          signed quantized coefficient
//   out_index [5:0]         zigzag position of out_data
//   out_last                high on the beat with out_index = 63
//   out_last_nz [5:0]       zigzag position of the last nonzero value (valid with out_last)
//   out_all_zero            every quantized value in the block is zero (valid with out_last)
module quant_zigzag (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [511:0]  coef_in,
  input  logic [1023:0] recip_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic [5:0]    out_index,
  output logic          out_last,
  output logic [5:0]    out_last_nz,
  output logic          out_all_zero
);

  typedef enum logic [1:0] {IDLE, EMIT, DRAIN} state_t;

  // Zigzag position -> natural index, packed with position 63 in the MSBs.
  localparam logic [383:0] ZZ_TABLE = {
    6'd63, 6'd62, 6'd55, 6'd47, 6'd54, 6'd61, 6'd60, 6'd53, 6'd46, 6'd39,
    6'd31, 6'd38, 6'd45, 6'd52, 6'd59, 6'd58, 6'd51, 6'd44, 6'd37, 6'd30,
    6'd23, 6'd15, 6'd22, 6'd29, 6'd36, 6'd43, 6'd50, 6'd57, 6'd56, 6'd49,
    6'd42, 6'd35, 6'd28, 6'd21, 6'd14, 6'd7,  6'd6,  6'd13, 6'd20, 6'd27,
    6'd34, 6'd41, 6'd48, 6'd40, 6'd33, 6'd26, 6'd19, 6'd12, 6'd5,  6'd4,
    6'd11, 6'd18, 6'd25, 6'd32, 6'd24, 6'd17, 6'd10, 6'd3,  6'd2,  6'd9,
    6'd16, 6'd8,  6'd1,  6'd0
  };

  state_t          state_q, state_d;
  logic [5:0]      ptr_q, ptr_d;
  logic            nz_seen_q, nz_seen_d;
  logic [5:0]      last_nz_q, last_nz_d;
  logic [511:0]    coef_buf_q, coef_buf_d;
  logic [1023:0]   recip_buf_q, recip_buf_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q, out_data_d;
  logic [5:0]      out_index_q, out_index_d;
  logic            out_last_q, out_last_d;
  logic [5:0]      out_last_nz_q, out_last_nz_d;
  logic            out_all_zero_q, out_all_zero_d;

  logic [8:0]      zz_off;
  logic [5:0]      nat;
  logic [7:0]      coef;
  logic [15:0]     recip;
  logic [8:0]      coef_ext;
  logic [8:0]      mag_in;
  logic [25:0]     prod;
  logic [7:0]      mag_q;
  logic [7:0]      q_val;
  logic            q_nz;
  logic            nz_next;
  logic [5:0]      last_next;
  logic            load_en;

  // Quantizer datapath for the coefficient at the current zigzag pointer.
  always_comb begin
    zz_off   = 9'({3'b000, ptr_q} * 9'd6);
    nat      = ZZ_TABLE[zz_off +: 6];
    coef     = coef_buf_q[{nat, 3'b000} +: 8];
    recip    = recip_buf_q[{nat, 4'b0000} +: 16];
    coef_ext = {coef[7], coef};
    mag_in   = coef[7] ? (~coef_ext + 9'd1) : coef_ext;
    prod     = 26'(mag_in) * 26'(recip) + 26'd32768;
    // |q| never exceeds 128, so the low 8 bits of the rounded magnitude suffice.
    mag_q    = prod[23:16];
    q_val    = coef[7] ? (~mag_q + 8'd1) : mag_q;
    q_nz     = (mag_q != 8'd0);
    if (ptr_q == 6'd0) begin
      nz_next   = q_nz;
      last_next = 6'd0;
    end else begin
      nz_next   = nz_seen_q | q_nz;
      last_next = q_nz ? ptr_q : last_nz_q;
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    nz_seen_d      = nz_seen_q;
    last_nz_d      = last_nz_q;
    coef_buf_d     = coef_buf_q;
    recip_buf_d    = recip_buf_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_index_d    = out_index_q;
    out_last_d     = out_last_q;
    out_last_nz_d  = out_last_nz_q;
    out_all_zero_d = out_all_zero_q;
    load_en        = !out_valid_q || out_ready;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          coef_buf_d  = coef_in;
          recip_buf_d = recip_in;
          ptr_d       = '0;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (load_en) begin
          out_valid_d    = 1'b1;
          out_data_d     = q_val;
          out_index_d    = ptr_q;
          out_last_d     = (ptr_q == 6'd63);
          out_last_nz_d  = (ptr_q == 6'd63 && nz_next) ? last_next : 6'd0;
          out_all_zero_d = (ptr_q == 6'd63) && !nz_next;
          nz_seen_d      = nz_next;
          last_nz_d      = last_next;
          ptr_d          = ptr_q + 6'd1;
          if (ptr_q == 6'd63) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      nz_seen_q      <= 1'b0;
      last_nz_q      <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_index_q    <= '0;
      out_last_q     <= 1'b0;
      out_last_nz_q  <= '0;
      out_all_zero_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      nz_seen_q      <= nz_seen_d;
      last_nz_q      <= last_nz_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_index_q    <= out_index_d;
      out_last_q     <= out_last_d;
      out_last_nz_q  <= out_last_nz_d;
      out_all_zero_q <= out_all_zero_d;
    end
  end

  // Block buffers need no reset: they are always reloaded before use.
  always_ff @(posedge clock) begin
    coef_buf_q  <= coef_buf_d;
    recip_buf_q <= recip_buf_d;
  end

  assign in_ready     = (state_q == IDLE) && !reset;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_index    = out_index_q;
  assign out_last     = out_last_q;
  assign out_last_nz  = out_last_nz_q;
  assign out_all_zero = out_all_zero_q;

endmodule

// File: tb/tb_quant_zigzag.sv
// Testbench for quant_zigzag: directed and randomized blocks checked against
// a queue-based reference model built from the zigzag walk and integer math.
module tb_quant_zigzag;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [511:0]  coef_in = '0;
  logic [1023:0] recip_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    out_data;
  logic [5:0]    out_index;
  logic          out_last;
  logic [5:0]    out_last_nz;
  logic          out_all_zero;

  always #5 clock = ~clock;

  quant_zigzag dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .coef_in(coef_in), .recip_in(recip_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .out_last_nz(out_last_nz), .out_all_zero(out_all_zero)
  );

  typedef struct {
    int data;
    int index;
    bit last;
    int last_nz;
    bit all_zero;
  } beat_t;

  beat_t exp_q[$];
  int    zz[64];
  int    total = 0;
  int    bad = 0;
  int    ready_mode = 0;
  int    beat_cnt = 0;
  int    hs_age = -1;
  bit    prev_rst = 1'b0;
  bit    stall_prev = 1'b0;
  logic [7:0] s_data;
  logic [5:0] s_index, s_lnz;
  logic       s_last, s_az;

  task automatic check(input bit ok, input string name, input int act, input int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int quant(input int c, input int r);
    int m, mag;
    m   = (c < 0) ? -c : c;
    mag = (m * r + 32768) / 65536;
    return (c < 0) ? -mag : mag;
  endfunction

  // Walk the anti-diagonals of the 8x8 grid, alternating direction.
  function automatic void build_zz();
    int p, lo, hi;
    p = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz[p] = r * 8 + (s - r); p++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz[p] = r * 8 + (s - r); p++; end
      end
    end
  endfunction

  task automatic push_block();
    beat_t b;
    bit nz;
    int ln, n, c, r, q;
    logic signed [7:0] cs;
    nz = 1'b0;
    ln = 0;
    for (int p = 0; p < 64; p++) begin
      n  = zz[p];
      cs = coef_in[8*n +: 8];
      c  = cs;
      r  = int'(recip_in[16*n +: 16]);
      q  = quant(c, r);
      if (q != 0) begin nz = 1'b1; ln = p; end
      b.data     = q;
      b.index    = p;
      b.last     = (p == 63);
      b.last_nz  = ln;
      b.all_zero = !nz;
      exp_q.push_back(b);
    end
  endtask

  // Compare process: all DUT outputs sampled on the falling edge.
  always @(negedge clock) begin
    beat_t b;
    bit idle;
    if (reset) begin
      exp_q.delete();
      hs_age     = -1;
      stall_prev = 1'b0;
      check(in_ready == 1'b0, "in_ready_during_reset", int'(in_ready), 0);
      prev_rst = 1'b1;
    end else begin
      if (prev_rst) begin
        check(out_valid == 1'b0, "out_valid_after_reset", int'(out_valid), 0);
        check(in_ready == 1'b1, "in_ready_after_reset", int'(in_ready), 1);
        check(out_data == 8'd0 && out_index == 6'd0 && !out_last && out_last_nz == 6'd0
              && !out_all_zero, "outputs_after_reset", int'(out_data), 0);
      end
      prev_rst = 1'b0;
      idle = (exp_q.size() == 0) && !out_valid;
      check(in_ready == idle, "in_ready", int'(in_ready), int'(idle));
      if (hs_age == 1) check(out_valid == 1'b0, "latency_e0", int'(out_valid), 0);
      if (hs_age == 2) check(out_valid == 1'b1 && out_index == 6'd0, "latency_e1",
                             int'(out_index), 0);
      if (stall_prev)
        check(out_valid && out_data == s_data && out_index == s_index && out_last == s_last
              && out_last_nz == s_lnz && out_all_zero == s_az, "stall_hold",
              int'(out_index), int'(s_index));
      if (ready_mode == 0 && exp_q.size() > 0 && hs_age >= 2)
        check(out_valid == 1'b1, "no_gap", int'(out_valid), 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_beat", int'(out_index), -1);
        end else begin
          b = exp_q.pop_front();
          check($signed(out_data) == b.data, "data", int'($signed(out_data)), b.data);
          check(int'(out_index) == b.index, "index", int'(out_index), b.index);
          check(out_last == b.last, "last", int'(out_last), int'(b.last));
          if (b.last) begin
            check(int'(out_last_nz) == b.last_nz, "last_nz", int'(out_last_nz), b.last_nz);
            check(out_all_zero == b.all_zero, "all_zero", int'(out_all_zero), int'(b.all_zero));
          end
          beat_cnt++;
        end
      end
      stall_prev = out_valid && !out_ready;
      s_data = out_data; s_index = out_index; s_last = out_last;
      s_lnz = out_last_nz; s_az = out_all_zero;
      if (in_valid && in_ready) begin
        push_block();
        hs_age = 1;
      end else if (hs_age >= 1 && hs_age < 100000) begin
        hs_age++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_uniform(input int c, input int r);
    for (int k = 0; k < 64; k++) begin
      coef_in[8*k +: 8]   = 8'(c);
      recip_in[16*k +: 16] = 16'(r);
    end
  endtask

  task automatic set_random();
    for (int k = 0; k < 64; k++) begin
      coef_in[8*k +: 8]    = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
      recip_in[16*k +: 16] = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
    end
  endtask

  task automatic scramble();
    coef_in  = {16{$urandom}};
    recip_in = {32{$urandom}};
  endtask

  task automatic handshake();
    bit hs;
    int n;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clock);
      hs = in_ready;
      @(posedge clock);
      #1;
      if (hs) break;
      n++;
      if (n > 500) begin check(1'b0, "handshake_timeout", n, 500); break; end
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 || out_valid) begin
      @(posedge clock);
      #1;
      n++;
      if (n > 2000) begin check(1'b0, "drain_timeout", n, 2000); break; end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run_block();
    handshake();
    in_valid = 1'b0;
    scramble();
    wait_done();
  endtask

  initial begin
    int start, n;
    build_zz();
    check(zz[2] == 8, "zz_pin2", zz[2], 8);
    check(zz[5] == 2, "zz_pin5", zz[5], 2);
    check(zz[20] == 40, "zz_pin20", zz[20], 40);
    check(zz[35] == 56, "zz_pin35", zz[35], 56);
    check(zz[63] == 63, "zz_pin63", zz[63], 63);
    check(quant(8, 4096) == 1, "q_pin_8", quant(8, 4096), 1);
    check(quant(7, 4096) == 0, "q_pin_7", quant(7, 4096), 0);
    check(quant(-8, 4096) == -1, "q_pin_m8", quant(-8, 4096), -1);
    check(quant(-7, 4096) == 0, "q_pin_m7", quant(-7, 4096), 0);
    check(quant(-40, 2048) == -1, "q_pin_m40", quant(-40, 2048), -1);
    check(quant(16, 4096) == 1, "q_pin_16", quant(16, 4096), 1);
    check(quant(-128, 65535) == -128, "q_pin_m128", quant(-128, 65535), -128);
    check(quant(127, 65535) == 127, "q_pin_127", quant(127, 65535), 127);
    check(quant(100, 0) == 0, "q_pin_r0", quant(100, 0), 0);

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Uniform block: every beat is 1, last nonzero at 63.
    set_uniform(16, 4096);
    run_block();

    // Lone DC coefficient, then an all-zero block.
    set_uniform(0, 2048);
    coef_in[7:0] = 8'hD8;
    run_block();
    set_uniform(0, 2048);
    run_block();

    // Rounding at the half boundary in both signs.
    set_uniform(0, 4096);
    coef_in[8*0 +: 8]  = 8'd8;
    coef_in[8*1 +: 8]  = 8'd7;
    coef_in[8*8 +: 8]  = 8'hF8;
    coef_in[8*16 +: 8] = 8'hF9;
    run_block();

    // Identity values expose the zigzag map on out_data.
    for (int k = 0; k < 64; k++) begin
      coef_in[8*k +: 8]    = 8'(k);
      recip_in[16*k +: 16] = 16'hFFFF;
    end
    run_block();

    // Random blocks, free-flowing then with back-pressure.
    for (int i = 0; i < 4; i++) begin set_random(); run_block(); end
    ready_mode = 1;
    for (int i = 0; i < 4; i++) begin set_random(); run_block(); end

    // Back-to-back request with in_valid held across the first block.
    set_random();
    handshake();
    set_random();
    handshake();
    in_valid = 1'b0;
    scramble();
    wait_done();

    // Reset in the middle of a block.
    ready_mode = 0;
    set_random();
    start = beat_cnt;
    handshake();
    in_valid = 1'b0;
    n = 0;
    while (beat_cnt < start + 21) begin
      @(posedge clock);
      #1;
      n++;
      if (n > 500) begin check(1'b0, "midblock_timeout", n, 500); break; end
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    set_random();
    run_block();

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/quant_zigzag.md
QUANT_ZIGZAG -- requirements
Module: quant_zigzag

Interface
REQ-001 Parameters: none; all widths are fixed as stated below.
REQ-002 clock  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  a DCT block is presented on coef_in.
REQ-005 in_ready  out  1  block accepted on a clock edge where in_valid=1 and in_ready=1.
REQ-006 coef_in  in  512  64 signed 8-bit 2D-DCT coefficients, row-major; natural index k occupies bits [8k+7:8k].
REQ-007 recip_in  in  1024  64 unsigned 16-bit reciprocals, recip = round(65536/Q), natural index k at bits [16k+15:16k]; sampled together with coef_in.
REQ-008 out_valid  out  1  an output beat is presented.
REQ-009 out_ready  in  1  consumer accepts the beat when out_valid=1 and out_ready=1.
REQ-010 out_data  out  8  signed quantized coefficient.
REQ-011 out_index  out  6  zigzag position of out_data, 0..63.
REQ-012 out_last  out  1  high on the beat with out_index=63.
REQ-013 out_last_nz  out  6  zigzag position of the last nonzero coefficient in the block; valid only when out_last=1.
REQ-014 out_all_zero  out  1  all 64 quantized values are 0; valid only when out_last=1.

Function
REQ-015 FSM states: IDLE, EMIT, DRAIN. in_ready=1 only in IDLE and never while reset=1.
REQ-016 IDLE to EMIT on the in_valid/in_ready handshake edge: coef_in and recip_in are latched into internal buffers and zigzag pointer ptr=0.
REQ-017 Output register load enable = !out_valid || out_ready.
REQ-018 In EMIT, on each enabled edge, the output register loads the value for ptr (out_index=ptr, out_valid=1) and ptr increments; the load at ptr=63 moves the FSM to DRAIN.
REQ-019 In DRAIN, on the edge where the out_index=63 beat handshakes, out_valid drops to 0 and the FSM returns to IDLE.
REQ-020 in_ready is 1 in the cycle after that edge; the block never overlaps with the next one.
REQ-021 Latency: the handshake edge is E0; the beat with out_index=0 is valid after edge E1.
REQ-022 With out_ready held at 1, the block emits 64 beats on consecutive cycles.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_index, out_last, out_last_nz and out_all_zero hold stable.
REQ-024 Zigzag order uses the standard JPEG map (zigzag position to natural index): 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
REQ-025 Quantization per coefficient: m=|c| (9-bit), |q| = (m*recip + 32768) >> 16, computed in at least 26 bits; the sign of c is reapplied, so a half rounds away from zero. A zero |q| is output as 0, never -0.
REQ-026 out_data needs no saturation: the range for 16-bit recip is -128..127.
REQ-027 A running last-nonzero tracker is reset to "none" at ptr=0 and updated with the zigzag position on each nonzero q.
REQ-028 On the out_last beat, out_last_nz = tracker value (0 if none) and out_all_zero = (none).
REQ-029 in_valid asserted outside IDLE is ignored; coef_in and recip_in changes after the handshake do not affect the block in flight.
REQ-030 recip=0 yields q=0 (legal, no special case).

Reset
REQ-031 While reset=1 on an edge: FSM=IDLE, ptr=0, tracker=none, out_valid=0, out_data=0, out_index=0, out_last=0, out_last_nz=0, out_all_zero=0, in_ready=0.
REQ-032 Reset mid-block discards the block in flight with no further beats; in_ready=1 in the first cycle with reset=0.

Verification
REQ-033 All coef=16, all recip=4096, out_ready=1: 64 consecutive beats of data=1, index 0..63; out_last on the 64th beat with last_nz=63, all_zero=0; in_ready=1 the next cycle.
REQ-034 coef[0]=-40, others 0, recip=2048: beat0 data=-1, other beats 0; last_nz=0, all_zero=0. Repeat with coef[0]=0: all_zero=1, last_nz=0.
REQ-035 Rounding, recip=4096: coef 8 gives 1, coef 7 gives 0, coef -8 gives -1, coef -7 gives 0.
REQ-036 coef[k]=k, recip=65535: out_data sequence equals the REQ-024 map (0,1,8,16,9,2,...,63).
REQ-037 out_ready random 50% with in_valid held at 1: outputs stable during stalls, exactly 64 beats in order, second block accepted only after the last handshake; first beat of block 2 has index 0.
REQ-038 Reset asserted 1 cycle after beat 20: out_valid=0 next cycle; in_ready=1 after release; the next block emits from index 0 with correct data.
